sign_extend: RTL and testbench

Parameterised two's-complement sign extender for the pipelined MIPS datapath: widens a narrow immediate field to the full datapath word by replicating its most significant bit. The primary result is purely combinational, so the decode stage sees it in the same cycle. A registered copy plus status flags, clocked and reset like the rest of the pipeline, serve the next pipeline stage.

---
 rtl/sign_extend_if.sv | 15 +
 rtl/sign_extend.sv | 41 ++++
 tb/tb_sign_extend.sv | 98 +++++++++
 3 files changed

// File: rtl/sign_extend_if.sv
// sign_extend_if: immediate-in / extended-result bundle between decode and the sign extender.
interface sign_extend_if #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  in;
    logic [OUT_WIDTH-1:0] extended_out;
    logic [OUT_WIDTH-1:0] extended_q;
    logic                 neg_q;
    logic                 zero_q;
    logic                 valid_q;

    modport master (output in, input extended_out, extended_q, neg_q, zero_q, valid_q);
    modport slave  (input in, output extended_out, extended_q, neg_q, zero_q, valid_q);
endinterface

// File: rtl/sign_extend.sv
// sign_extend: two's-complement widening of an immediate, combinational result plus a registered copy.
module sign_extend #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    sign_extend_if.slave  bus
);
    if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : g_bad_width
        $error("sign_extend: IN_WIDTH must be within 1..OUT_WIDTH");
    end

    logic [OUT_WIDTH-1:0] extended_d;
    logic                 neg_d;
    logic                 zero_d;

    // A signed size cast replicates the sign bit and handles IN_WIDTH == OUT_WIDTH without a zero-width replication.
    always_comb begin
        extended_d = OUT_WIDTH'($signed(bus.in));
        neg_d      = bus.in[IN_WIDTH-1];
        zero_d     = (bus.in == '0);
    end

    assign bus.extended_out = extended_d;

    // rst is active-low
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.extended_q <= '0;
            bus.neg_q      <= 1'b0;
            bus.zero_q     <= 1'b0;
            bus.valid_q    <= 1'b0;
        end else begin
            bus.extended_q <= extended_d;
            bus.neg_q      <= neg_d;
            bus.zero_q     <= zero_d;
            bus.valid_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: table-driven vectors with a scoreboard for the registered path, plus clock-idle and full-width cases.
module tb_sign_extend;
    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = clk_en ? ~clk : clk;

    sign_extend_if #(.IN_WIDTH(4), .OUT_WIDTH(16)) bus ();
    sign_extend_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) bus_w ();

    sign_extend #(.IN_WIDTH(4), .OUT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    sign_extend #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct {
        logic [3:0]  v;
        logic        r;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] ext;
        logic        neg;
        logic        zero;
        logic        valid;
    } reg_t;

    reg_t sb[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t t);
        reg_t e;
        @(negedge clk);
        bus.in = t.v;
        rst = t.r;
        #1;
        check("extended_out", bus.extended_out, t.exp);
        e.ext   = t.r ? t.exp : 16'h0000;
        e.neg   = t.r ? t.exp[15] : 1'b0;
        e.zero  = t.r ? (t.exp == 16'h0000) : 1'b0;
        e.valid = t.r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("extended_q", bus.extended_q, e.ext);
        check("neg_q", {15'd0, bus.neg_q}, {15'd0, e.neg});
        check("zero_q", {15'd0, bus.zero_q}, {15'd0, e.zero});
        check("valid_q", {15'd0, bus.valid_q}, {15'd0, e.valid});
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 16'h0000};
        vecs[1]  = '{4'b0001, 1'b1, 16'h0001};
        vecs[2]  = '{4'b1000, 1'b1, 16'hFFF8};
        vecs[3]  = '{4'b1111, 1'b1, 16'hFFFF};
        vecs[4]  = '{4'b1001, 1'b1, 16'hFFF9};
        vecs[5]  = '{4'b0000, 1'b1, 16'h0000};
        vecs[6]  = '{4'b0111, 1'b1, 16'h0007};
        vecs[7]  = '{4'b1111, 1'b0, 16'hFFFF};
        vecs[8]  = '{4'b1111, 1'b0, 16'hFFFF};
        vecs[9]  = '{4'b1111, 1'b1, 16'hFFFF};
        vecs[10] = '{4'b0101, 1'b1, 16'h0005};
        vecs[11] = '{4'b1010, 1'b0, 16'hFFFA};
        vecs[12] = '{4'b0110, 1'b1, 16'h0006};
        bus.in = 4'b0000;
        bus_w.in = 16'h0000;
        for (int i = 0; i < 13; i++) apply(vecs[i]);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        @(negedge clk);
        clk_en = 1'b0;
        bus.in = 4'b1111;
        #10 check("idle 1111", bus.extended_out, 16'hFFFF);
        bus.in = 4'b1001;
        #10 check("idle 1001", bus.extended_out, 16'hFFF9);
        bus.in = 4'b0011;
        #10 check("idle 0011", bus.extended_out, 16'h0003);
        check("idle hold extended_q", bus.extended_q, 16'h0006);
        bus_w.in = 16'h8001;
        #10 check("w16 8001", bus_w.extended_out, 16'h8001);
        bus_w.in = 16'h7FFE;
        #10 check("w16 7FFE", bus_w.extended_out, 16'h7FFE);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
